// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program-counter sequencer: PC register, imem req/ack handshake, redirects and stalls.
// Optional misaligned-redirect trap enabled by defining PC_CTRL_TRAP_EN.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        pc_sel,
   output logic        if_valid,
`ifdef PC_CTRL_TRAP_EN
   output logic        trap_valid,
   output logic [31:0] trap_epc,
`endif
   output logic        flush
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      STALL = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic        flush_q, flush_d;
   logic [31:0] redir_tgt;
`ifdef PC_CTRL_TRAP_EN
   logic        trap_valid_q, trap_valid_d;
   logic [31:0] trap_epc_q, trap_epc_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         pend_q  <= 32'h0;
         flush_q <= 1'b0;
`ifdef PC_CTRL_TRAP_EN
         trap_valid_q <= 1'b0;
         trap_epc_q   <= 32'h0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         flush_q <= flush_d;
`ifdef PC_CTRL_TRAP_EN
         trap_valid_q <= trap_valid_d;
         trap_epc_q   <= trap_epc_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_d    = pend_q;
      imem_req  = 1'b0;
      if_valid  = 1'b0;
      pc_sel    = 1'b0;
      redir_tgt = br_target;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (br_taken) begin
                  pc_sel = 1'b1;
               end else begin
                  if_valid = 1'b1;
                  pc_d     = pc4;
               end
               state_d = stall ? STALL : FETCH;
            end else if (br_taken) begin
               pend_d  = br_target;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            imem_req = 1'b1;
            if (br_taken) begin
               pend_d = br_target;
            end
            if (imem_ack) begin
               // The acked instruction is wrong-path; the newest redirect wins.
               pc_sel    = 1'b1;
               redir_tgt = br_taken ? br_target : pend_q;
               state_d   = stall ? STALL : FETCH;
            end
         end
         STALL: begin
            if (br_taken) begin
               pc_sel = 1'b1;
            end
            if (!stall) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      flush_d = pc_sel;
`ifdef PC_CTRL_TRAP_EN
      trap_valid_d = 1'b0;
      trap_epc_d   = trap_epc_q;
      if (pc_sel) begin
         if (redir_tgt[1:0] != 2'b00) begin
            pc_d         = TRAP_VECTOR;
            trap_valid_d = 1'b1;
            trap_epc_d   = redir_tgt;
         end else begin
            pc_d = redir_tgt;
         end
      end
`else
      if (pc_sel) begin
         pc_d = redir_tgt & 32'hFFFF_FFFC;
      end
`endif
   end

   assign pc        = pc_q;
   assign pc4       = pc_q + 32'd4;
   assign imem_addr = pc_q;
   assign flush     = flush_q;
`ifdef PC_CTRL_TRAP_EN
   assign trap_valid = trap_valid_q;
   assign trap_epc   = trap_epc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl; expected values are hand-computed per cycle.
// Define PC_CTRL_TRAP_EN to exercise the misaligned-redirect trap build.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        imem_ack;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        pc_sel;
   logic        if_valid;
   logic        flush;
`ifdef PC_CTRL_TRAP_EN
   logic        trap_valid;
   logic [31:0] trap_epc;
   localparam logic [31:0] PC_AFTER_42 = 32'h0000_0100;
`else
   localparam logic [31:0] PC_AFTER_42 = 32'h0000_0040;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pc_fetch_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .br_taken  (br_taken),
      .br_target (br_target),
      .imem_ack  (imem_ack),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .pc        (pc),
      .pc4       (pc4),
      .pc_sel    (pc_sel),
      .if_valid  (if_valid),
`ifdef PC_CTRL_TRAP_EN
      .trap_valid(trap_valid),
      .trap_epc  (trap_epc),
`endif
      .flush     (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are changed 1ns after the edge, outputs sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; imem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_ifv", {31'b0, if_valid}, 32'h0);
      chk("rst_flush", {31'b0, flush}, 32'h0);
      chk("rst_pcsel", {31'b0, pc_sel}, 32'h0);
`ifdef PC_CTRL_TRAP_EN
      chk("rst_trapv", {31'b0, trap_valid}, 32'h0);
      chk("rst_epc", trap_epc, 32'h0);
`endif

      // IDLE cycle: ack already high must be ignored
      rst = 1'b0; imem_ack = 1'b1; #1;
      chk("idle_req", {31'b0, imem_req}, 32'h0);
      chk("idle_ifv", {31'b0, if_valid}, 32'h0);
      step();
      chk("f0_addr", imem_addr, 32'h0);
      chk("f0_req", {31'b0, imem_req}, 32'h1);
      chk("f0_ifv", {31'b0, if_valid}, 32'h1);
      step();
      chk("f1_addr", imem_addr, 32'h4);
      chk("f1_ifv", {31'b0, if_valid}, 32'h1);
      step();
      stall = 1'b1; #1;
      chk("f2_addr", imem_addr, 32'h8);
      chk("f2_ifv", {31'b0, if_valid}, 32'h1);

      // Stall: four cycles with no request, PC parked at 0xC
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 3) begin
            stall = 1'b0; #1;
         end
         chk("stall_req", {31'b0, imem_req}, 32'h0);
         chk("stall_pc", pc, 32'hC);
      end
      step();
      chk("resume_addr", imem_addr, 32'hC);
      chk("resume_req", {31'b0, imem_req}, 32'h1);

      // Redirect with ack in FETCH
      br_taken = 1'b1; br_target = 32'h40; #1;
      chk("br_ifv", {31'b0, if_valid}, 32'h0);
      chk("br_pcsel", {31'b0, pc_sel}, 32'h1);
      step();
      br_taken = 1'b0; #1;
      chk("br_flush", {31'b0, flush}, 32'h1);
      chk("br_addr", imem_addr, 32'h40);
      chk("br_ifv2", {31'b0, if_valid}, 32'h1);
      step();
      chk("br_flush_off", {31'b0, flush}, 32'h0);
      chk("br_addr2", imem_addr, 32'h44);
      step();

      // Delayed ack, two redirects while waiting: newest wins
      imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h80; #1;
      chk("dr_addr0", imem_addr, 32'h48);
      chk("dr_pcsel0", {31'b0, pc_sel}, 32'h0);
      chk("dr_ifv0", {31'b0, if_valid}, 32'h0);
      step();
      br_target = 32'h90; #1;
      chk("dr_addr1", imem_addr, 32'h48);
      chk("dr_req1", {31'b0, imem_req}, 32'h1);
      step();
      br_taken = 1'b0; #1;
      chk("dr_addr2", imem_addr, 32'h48);
      step();
      imem_ack = 1'b1; #1;
      chk("dr_ack_ifv", {31'b0, if_valid}, 32'h0);
      chk("dr_ack_pcsel", {31'b0, pc_sel}, 32'h1);
      step();
      chk("dr_new_addr", imem_addr, 32'h90);
      chk("dr_flush", {31'b0, flush}, 32'h1);
      chk("dr_ifv", {31'b0, if_valid}, 32'h1);
      step();
      chk("dr_seq", imem_addr, 32'h94);

      // PC+4 wrap
      br_taken = 1'b1; br_target = 32'hFFFF_FFFC; #1;
      step();
      br_taken = 1'b0; #1;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc4, 32'h0);
      step();
      chk("wrap_pc", pc, 32'h0);

      // Misaligned redirect
      br_taken = 1'b1; br_target = 32'h42; #1;
      step();
      br_taken = 1'b0; stall = 1'b1; #1;
      chk("mis_pc", pc, PC_AFTER_42);
      chk("mis_flush", {31'b0, flush}, 32'h1);
`ifdef PC_CTRL_TRAP_EN
      chk("mis_trapv", {31'b0, trap_valid}, 32'h1);
      chk("mis_epc", trap_epc, 32'h42);
`endif
      step();
      chk("mis_pc2", pc, PC_AFTER_42 + 32'd4);
      chk("mis_flush_off", {31'b0, flush}, 32'h0);
      chk("mis_req", {31'b0, imem_req}, 32'h0);
`ifdef PC_CTRL_TRAP_EN
      chk("mis_trapv_off", {31'b0, trap_valid}, 32'h0);
`endif

      // Redirect while in STALL
      br_taken = 1'b1; br_target = 32'h200; #1;
      chk("st_pcsel", {31'b0, pc_sel}, 32'h1);
      step();
      br_taken = 1'b0; #1;
      chk("st_pc", pc, 32'h200);
      chk("st_flush", {31'b0, flush}, 32'h1);
      chk("st_req", {31'b0, imem_req}, 32'h0);
      stall = 1'b0;
      step();
      chk("st_resume", imem_addr, 32'h200);
      chk("st_resume_req", {31'b0, imem_req}, 32'h1);

      // Asynchronous reset mid-handshake
      imem_ack = 1'b0; #2;
      rst = 1'b1; #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_req", {31'b0, imem_req}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; imem_ack = 1'b1; #1;
      chk("arst_idle_ifv", {31'b0, if_valid}, 32'h0);
      chk("arst_idle_req", {31'b0, imem_req}, 32'h0);
      step();
      chk("arst_fetch", imem_addr, 32'h0);
      chk("arst_fetch_ifv", {31'b0, if_valid}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter sequencer for the fetch stage. Owns the PC register, drives the instruction-memory request/acknowledge handshake and the next-PC select of the fetch mux (sequential PC+4 vs. redirect target), and applies stalls and branch/jump redirects from later pipeline stages. Wrong-path fetches already in flight are dropped.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, misaligned-target handler address (used only with PC_CTRL_TRAP_EN)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode stage cannot accept a new instruction
- br_taken  in  1  redirect request, single-cycle pulse
- br_target  in  32  redirect address, valid with br_taken
- imem_ack  in  1  memory returns the instruction for imem_addr
- imem_req  out  1  fetch request; held with stable imem_addr until imem_ack
- imem_addr  out  32  fetch address (registered PC)
- pc  out  32  current PC register
- pc4  out  32  pc + 4, modulo 2^32
- pc_sel  out  1  combinational; 1 when this cycle's PC update uses the redirect target
- if_valid  out  1  combinational; fetched instruction is valid for decode this cycle
- flush  out  1  registered; one-cycle pulse the cycle after a redirect is accepted
- trap_valid  out  1  (PC_CTRL_TRAP_EN only) one-cycle registered pulse on misaligned redirect
- trap_epc  out  32  (PC_CTRL_TRAP_EN only) offending target

## Operation
- Reset: pc=RESET_VECTOR, state IDLE, imem_req=0, if_valid=0, flush=0, pc_sel=0, trap_valid=0, trap_epc=0, pending target=0.
- IDLE: imem_req=0; unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc.
  - ack, no br_taken: if_valid=1, pc<=pc4; -> STALL if stall, else stay FETCH.
  - ack with br_taken: if_valid=0, pc_sel=1, pc<=br_target, flush next cycle; -> STALL if stall, else FETCH.
  - br_taken without ack: latch br_target as pending; -> DRAIN; imem_req/imem_addr unchanged.
- DRAIN: imem_req=1, same address. Further br_taken overwrites pending target (newest wins). On ack: if_valid=0, pc_sel=1, pc<=pending (or br_target if br_taken is coincident), flush next cycle; -> STALL if stall, else FETCH.
- STALL: imem_req=0, pc held. br_taken: pc_sel=1, pc<=br_target, flush next cycle. -> FETCH when stall=0.
- Priority: redirect over stall over sequential advance.
- pc4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 without flag.

## Timing
- Fetch latency = imem_ack latency; zero-wait memory (ack same cycle as req) sustains one instruction per cycle.
- Redirect in FETCH/STALL with ack: new address presented on imem_addr the next cycle.
- Redirect during unacked fetch: new address presented the cycle after the pending ack.
- flush asserted exactly one cycle, cycle after pc_sel=1.
- rst asserted mid-handshake: all state cleared immediately; outstanding ack after release while in IDLE is ignored.

## Configuration
- PC_CTRL_TRAP_EN defined: redirect target with [1:0]!=0 loads pc<=TRAP_VECTOR instead, trap_epc<=target, trap_valid pulses next cycle alongside flush; trap_valid/trap_epc ports exist.
- Undefined: ports absent; target[1:0] forced to 2'b00 on every redirect.

## Test plan
- Reset release, imem_ack tied 1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles, if_valid=1 each.
- br_taken target 0x40 with ack in FETCH -> if_valid=0 that cycle, flush next cycle, imem_addr=0x40 next cycle.
- ack delayed 3 cycles, br_taken 0x80 then 0x90 during wait -> stale instruction dropped, next fetch address 0x90.
- stall held 4 cycles after fetch of 0x8 -> imem_req=0 four cycles, pc=0xC, fetch resumes at 0xC.
- pc=0xFFFF_FFFC, ack -> pc wraps to 0x0.
- TRAP_EN: br_target 0x42 -> pc=0x100, trap_epc=0x42, trap_valid one cycle; without macro -> pc=0x40.
